mem_stim_gen: RTL and testbench

MEM_STIM_GEN -- requirements
Module: mem_stim_gen

---
 rtl/mem_stim_pkg.sv | 32 +++
 rtl/mem_stim_pat.sv | 61 ++++++
 rtl/mem_stim_gen.sv | 186 ++++++++++++++++++
 tb/tb_mem_stim_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stim_pkg.sv
// Shared definitions for the memory stimulus generator.
// Holds the data-pattern mode encoding, the sequencer state encoding and the
// Galois LFSR feedback polynomials for the supported data widths.
package mem_stim_pkg;

  // Data pattern modes
  localparam logic [1:0] ModeConst = 2'b00;
  localparam logic [1:0] ModeInc   = 2'b01;
  localparam logic [1:0] ModeWalk  = 2'b10;
  localparam logic [1:0] ModeLfsr  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWr    = 2'd1,
    StRd    = 2'd2,
    StDrain = 2'd3
  } state_e;

  // Right-shifting Galois feedback masks (maximal length)
  localparam logic [31:0] LfsrPoly8  = 32'h0000_00B8;
  localparam logic [31:0] LfsrPoly16 = 32'h0000_B400;
  localparam logic [31:0] LfsrPoly32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_poly(int unsigned width);
    case (width)
      16:      return LfsrPoly16;
      32:      return LfsrPoly32;
      default: return LfsrPoly8;
    endcase
  endfunction

endpackage

// File: rtl/mem_stim_pat.sv
// Pattern generator for the memory stimulus sequencer.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : capture mode and seed; value becomes pat(0) next cycle
//   step         : advance value to the next pattern element
//   mode, seed   : pattern mode and initial value (sampled on load)
//   value        : current pattern element (registered)
module mem_stim_pat
  import mem_stim_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value
);

  localparam logic [DATA_W-1:0] Poly = DATA_W'(lfsr_poly(DATA_W));

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] value_q, value_d, seed_fix;

  // A zero seed would lock walking-one and LFSR at zero forever.
  always_comb begin
    seed_fix = seed;
    if ((mode == ModeWalk || mode == ModeLfsr) && seed == '0) begin
      seed_fix = DATA_W'(1);
    end
  end

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_fix;
    end else if (step) begin
      case (mode_q)
        ModeInc:  value_d = value_q + DATA_W'(1);
        ModeWalk: value_d = {value_q[DATA_W-2:0], value_q[DATA_W-1]};
        ModeLfsr: value_d = (value_q >> 1) ^ (value_q[0] ? Poly : '0);
        default:  value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= ModeConst;
      value_q <= '0;
    end else begin
      if (load) mode_q <= mode;
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mem_stim_gen.sv
// Memory stimulus generator: writes a data pattern to a range of addresses,
// reading each location back right after writing it and counting mismatches.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   start         : launch pulse, honoured only when idle
//   mode, base, count, seed : sequence configuration, latched on start
//   rdata         : read data, slice i belongs to read port i
//   validdata, iWriteEnable, Readto, iAddress : memory write/read interface
//   busy, done    : sequence status; done pulses once at the end
//   err_cnt       : saturating readback mismatch count
module mem_stim_gen
  import mem_stim_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned N_RD   = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [ADDR_W-1:0]      base,
  input  logic [ADDR_W:0]        count,
  input  logic [DATA_W-1:0]      seed,
  input  logic [N_RD*DATA_W-1:0] rdata,
  output logic [DATA_W-1:0]      validdata,
  output logic                   iWriteEnable,
  output logic [N_RD-1:0]        Readto,
  output logic [ADDR_W-1:0]      iAddress,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            err_cnt
);

  localparam int unsigned PW = (N_RD > 1) ? $clog2(N_RD) : 1;

  state_e            state_q;
  logic [ADDR_W:0]   k_q, count_q, k_nx;
  logic [PW-1:0]     port_q, port_nx;
  logic [1:0]        drain_q;
  logic              we_q, busy_q, done_q;
  logic [N_RD-1:0]   rd_q, rd_onehot;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       err_q;
  logic [DATA_W-1:0] pat_value;
  logic              accept, pat_load, pat_step;

  // Compare pipeline: expected value and port of each read in flight
  logic [RD_LAT-1:0] pv_q;
  logic [DATA_W-1:0] pe_q [RD_LAT];
  logic [PW-1:0]     pp_q [RD_LAT];
  logic [DATA_W-1:0] cmp_slice;

  assign accept   = (state_q == StIdle) && start;
  assign k_nx     = k_q + 1'b1;
  assign port_nx  = (port_q == PW'(N_RD - 1)) ? '0 : port_q + 1'b1;
  // Pattern only moves when a new WR follows, so validdata holds otherwise.
  assign pat_load = accept && (count != '0);
  assign pat_step = (state_q == StRd) && (k_nx < count_q);

  always_comb begin
    rd_onehot         = '0;
    rd_onehot[port_q] = 1'b1;
  end

  mem_stim_pat #(
    .DATA_W(DATA_W)
  ) u_pat (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pat_load),
    .step   (pat_step),
    .mode   (mode),
    .seed   (seed),
    .value  (pat_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      count_q <= '0;
      port_q  <= '0;
      drain_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= count;
            k_q     <= '0;
            port_q  <= '0;
            busy_q  <= 1'b1;
            if (count == '0) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              state_q <= StWr;
              we_q    <= 1'b1;
              addr_q  <= base;
            end
          end
        end
        StWr: begin
          we_q    <= 1'b0;
          rd_q    <= rd_onehot;
          state_q <= StRd;
        end
        StRd: begin
          rd_q   <= '0;
          k_q    <= k_nx;
          port_q <= port_nx;
          if (k_nx < count_q) begin
            state_q <= StWr;
            we_q    <= 1'b1;
            addr_q  <= addr_q + ADDR_W'(1);
          end else begin
            state_q <= StDrain;
            drain_q <= '0;
          end
        end
        StDrain: begin
          if (drain_q == 2'(RD_LAT - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pe_q[i] <= '0;
        pp_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= (state_q == StRd);
      pe_q[0] <= pat_value;
      pp_q[0] <= port_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pp_q[i] <= pp_q[i-1];
      end
    end
  end

  always_comb begin
    cmp_slice = '0;
    for (int i = 0; i < int'(N_RD); i++) begin
      if (pp_q[RD_LAT-1] == PW'(i)) cmp_slice = rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else if (accept) begin
      err_q <= '0;
    end else if (pv_q[RD_LAT-1] && (cmp_slice != pe_q[RD_LAT-1]) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign validdata    = pat_value;
  assign iWriteEnable = we_q;
  assign Readto       = rd_q;
  assign iAddress     = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_mem_stim_gen.sv
// Bench for mem_stim_gen: directed sequences plus randomized ones, checked
// cycle by cycle against a reference computed from the pattern/address rules.
module tb_mem_stim_gen;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NR = 2;
  localparam int RL = 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic [AW-1:0]  base = '0;
  logic [AW:0]    count = '0;
  logic [DW-1:0]  seed = '0;
  logic [NR*DW-1:0] rdata = '0;
  logic [DW-1:0]  validdata;
  logic           iWriteEnable;
  logic [NR-1:0]  Readto;
  logic [AW-1:0]  iAddress;
  logic           busy;
  logic           done;
  logic [15:0]    err_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int last_addr = 0;
  int last_data = 0;
  bit force_a = 1'b0;
  bit force_b = 1'b0;
  logic [DW-1:0] mem [1<<AW];

  mem_stim_gen #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .N_RD  (NR),
    .RD_LAT(RL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mode        (mode),
    .base        (base),
    .count       (count),
    .seed        (seed),
    .rdata       (rdata),
    .validdata   (validdata),
    .iWriteEnable(iWriteEnable),
    .Readto      (Readto),
    .iAddress    (iAddress),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle read latency; a port can be forced to read 0xFF.
  always @(posedge clk) begin
    if (iWriteEnable) mem[iAddress] <= validdata;
    rdata <= {(force_b ? 8'hFF : mem[iAddress]), (force_a ? 8'hFF : mem[iAddress])};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pat_model(int m, int s, int k);
    int v;
    int r;
    case (m)
      0: return s;
      1: return (s + k) % 256;
      2: begin
        v = (s == 0) ? 1 : s;
        r = k % 8;
        return ((v << r) | (v >> (8 - r))) & 255;
      end
      default: begin
        v = (s == 0) ? 1 : s;
        repeat (k) v = (v & 1) ? ((v >> 1) ^ 'hB8) : (v >> 1);
        return v;
      end
    endcase
  endfunction

  task automatic run_seq(input int m, input int s, input int b, input int c,
                         input bit fa, input bit fb, input bit poke);
    int exp_err = 0;
    int d;
    int a;
    int p;
    @(negedge clk);
    force_a = fa;
    force_b = fb;
    mode = 2'(m);
    seed = 8'(s);
    base = 10'(b);
    count = 11'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 1);
    for (int k = 0; k < c; k++) begin
      d = pat_model(m, s, k);
      a = (b + k) % 1024;
      p = k % NR;
      check_eq("wr_we", {31'd0, iWriteEnable}, 1);
      check_eq("wr_rd", {30'd0, Readto}, 0);
      check_eq("wr_addr", {22'd0, iAddress}, a);
      check_eq("wr_data", {24'd0, validdata}, d);
      check_eq("wr_done", {31'd0, done}, 0);
      if (poke && k == 1) begin
        // Start while busy must be ignored.
        start = 1'b1;
        mode = 2'($urandom_range(0, 3));
        seed = 8'($urandom_range(0, 255));
        base = 10'($urandom_range(0, 1023));
        count = 11'($urandom_range(0, 20));
      end
      @(negedge clk);
      start = 1'b0;
      check_eq("rd_we", {31'd0, iWriteEnable}, 0);
      check_eq("rd_strobe", {30'd0, Readto}, 1 << p);
      check_eq("rd_addr", {22'd0, iAddress}, a);
      check_eq("rd_data", {24'd0, validdata}, d);
      if (((p == 1) ? fb : fa) && d != 255) exp_err++;
      last_addr = a;
      last_data = d;
      @(negedge clk);
    end
    for (int i = 0; i < RL; i++) begin
      check_eq("drain_we", {31'd0, iWriteEnable}, 0);
      check_eq("drain_rd", {30'd0, Readto}, 0);
      check_eq("drain_addr", {22'd0, iAddress}, last_addr);
      check_eq("drain_data", {24'd0, validdata}, last_data);
      check_eq("drain_done", {31'd0, done}, 0);
      check_eq("drain_busy", {31'd0, busy}, 1);
      @(negedge clk);
    end
    check_eq("done_pulse", {31'd0, done}, 1);
    check_eq("done_busy", {31'd0, busy}, 0);
    check_eq("done_err", {16'd0, err_cnt}, exp_err);
    check_eq("done_we", {31'd0, iWriteEnable}, 0);
    check_eq("done_addr", {22'd0, iAddress}, last_addr);
    @(negedge clk);
    check_eq("done_once", {31'd0, done}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, {31'd0, iWriteEnable}, 0);
    check_eq({tag, "_rd"}, {30'd0, Readto}, 0);
    check_eq({tag, "_addr"}, {22'd0, iAddress}, 0);
    check_eq({tag, "_data"}, {24'd0, validdata}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_done"}, {31'd0, done}, 0);
    check_eq({tag, "_err"}, {16'd0, err_cnt}, 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_seq(0, 8, 0, 1, 0, 0, 0);
    run_seq(1, 16, 10, 2, 0, 0, 0);
    run_seq(2, 'h20, 1023, 2, 0, 0, 0);
    run_seq(3, 0, 200, 4, 0, 1, 0);
    check_eq("lfsr_force_b_err", {16'd0, err_cnt}, 2);
    run_seq(0, 5, 3, 0, 0, 0, 0);

    // Reset during the second RD cycle aborts everything at once.
    @(negedge clk);
    mode = 2'd1; seed = 8'd40; base = 10'd100; count = 11'd4;
    force_a = 1'b1; force_b = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_rd", {30'd0, Readto}, 2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midseq");
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_no_done", {31'd0, done}, 0);
    end
    reset_n = 1'b1;
    force_a = 1'b0; force_b = 1'b0;
    last_addr = 0;
    last_data = 0;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_reset_done", {31'd0, done}, 0);
      check_eq("post_reset_err", {16'd0, err_cnt}, 0);
      check_eq("post_reset_we", {31'd0, iWriteEnable}, 0);
    end

    for (int t = 0; t < 30; t++) begin
      int m;
      int s;
      int b;
      int c;
      m = $urandom_range(0, 3);
      s = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      b = ($urandom_range(0, 1) == 1) ? $urandom_range(1015, 1023) : $urandom_range(0, 1023);
      c = $urandom_range(0, 12);
      run_seq(m, s, b, c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
